// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared state type and processor default sizes for the register file
package reg_file_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 3;

endpackage

// File: rtl/reg_file_init_ctrl.sv
// rtl/reg_file_init_ctrl.sv - INIT/RUN sequencer that sweeps every register to zero and raises ready
module reg_file_init_ctrl
   import reg_file_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   output logic                  clr_en_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o,
   output logic                  ready_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [ADDR_WIDTH-1:0] ptr_d;
   logic                  ready_q;

   assign ptr_d = ptr_q + 1'b1;

   // The last register is cleared on the same edge that enters RUN.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= INIT;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else if (state_q == INIT) begin
         if (ptr_q == LAST_ADDR) begin
            state_q <= RUN;
            ready_q <= 1'b1;
         end else begin
            ptr_q <= ptr_d;
         end
      end
   end

   assign clr_en_o   = (state_q == INIT);
   assign clr_addr_o = ptr_q;
   assign ready_o    = ready_q;

endmodule

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - two-read/one-write register file with clear sweep; REGFILE_BYPASS_EN adds write-to-read forwarding
module param_reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] WRITEDATA,
   input  logic [ADDR_WIDTH-1:0] WRITEREG,
   input  logic                  WRITEENABLE,
   input  logic [ADDR_WIDTH-1:0] READREG1,
   input  logic [ADDR_WIDTH-1:0] READREG2,
   output logic [DATA_WIDTH-1:0] REGOUT1,
   output logic [DATA_WIDTH-1:0] REGOUT2,
   output logic                  READY
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  ready;
   logic [DATA_WIDTH-1:0] rd1_d;
   logic [DATA_WIDTH-1:0] rd2_d;

   reg_file_init_ctrl #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_init_ctrl (
      .clk_i     (CLK),
      .resetn_i  (RESET),
      .clr_en_o  (clr_en),
      .clr_addr_o(clr_addr),
      .ready_o   (ready)
   );

   // Storage is deliberately left untouched on reset edges; the sweep clears it afterwards.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (clr_en) begin
            mem_q[clr_addr] <= '0;
         end else if (WRITEENABLE) begin
            mem_q[WRITEREG] <= WRITEDATA;
         end
      end
   end

   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      if (ready) begin
         rd1_d = mem_q[READREG1];
         rd2_d = mem_q[READREG2];
`ifdef REGFILE_BYPASS_EN
         if (WRITEENABLE && (READREG1 == WRITEREG)) rd1_d = WRITEDATA;
         if (WRITEENABLE && (READREG2 == WRITEREG)) rd2_d = WRITEDATA;
`endif
      end
   end

   assign REGOUT1 = rd1_d;
   assign REGOUT2 = rd2_d;
   assign READY   = ready;

endmodule

// File: doc/param_reg_file.md
# param_reg_file

Parametrised successor to the 8×8 two-read/one-write register file used in the simple processor datapath. It adds configurable data width and depth, a synchronous active-low reset that clears storage with a one-register-per-cycle sweep state machine and a READY indication, and optional write-to-read forwarding. It sits between instruction decode and the ALU: two combinational read ports feed the operands, and one clocked write port takes the ALU result.

## Interface
- DATA_WIDTH, default 8: width of each register and data port.
- ADDR_WIDTH, default 3: register address width; DEPTH = 2**ADDR_WIDTH registers.
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset), sampled on the CLK rising edge.
- WRITEDATA  input  DATA_WIDTH  data to write.
- WRITEREG  input  ADDR_WIDTH  write address.
- WRITEENABLE  input  1  write request, qualified by READY.
- READREG1, READREG2  input  ADDR_WIDTH  read addresses.
- REGOUT1, REGOUT2  output  DATA_WIDTH  read data.
- READY  output  1  high once the clear sweep has completed.

## Operation
- States are INIT and RUN. A rising edge with RESET=0 forces state to INIT, sweep pointer to 0 and READY to 0. Storage is not written during that edge.
- INIT, on each rising edge with RESET=1:
  - Write mem[ptr] = 0 and increment ptr.
  - When ptr == DEPTH-1, perform the final clear, go to RUN and set READY to 1.
- RUN: on a rising edge with RESET=1 and WRITEENABLE=1, write mem[WRITEREG] = WRITEDATA. WRITEENABLE=0 leaves memory unchanged.
- Writes requested in INIT are dropped silently. They are not queued.
- Read ports are combinational:
  - When READY=0, REGOUT1 and REGOUT2 are 0 regardless of address.
  - When READY=1, REGOUTx = mem[READREGx].
- Both read ports may address the same register, including the write target.
- Every address value is valid because depth is a power of two. An all-ones address such as -1 cast to ADDR_WIDTH selects register DEPTH-1.
- No arithmetic is performed; data passes through at DATA_WIDTH unchanged.

## Timing
- Reset values: READY=0, REGOUT1=0, REGOUT2=0, state INIT, ptr=0.
- READY rises on the DEPTH-th rising edge after the first edge that samples RESET=1. Example: 8 edges for ADDR_WIDTH=3.
- Write latency is 1 edge. Without forwarding, the new value appears on REGOUTx after the edge; before the edge the old value is shown.
- RESET=0 mid-sweep restarts the sweep at pointer 0. RESET=0 in RUN returns the block to INIT and drops READY on that edge. Registers keep stale contents until they are re-swept, but reads return 0 while READY=0.
- A write and a RESET=0 on the same edge: reset wins and the write is dropped.
- A read of an address during its write edge returns the pre-edge value, unless forwarding is compiled in.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When READY=1, WRITEENABLE=1 and READREGx == WRITEREG, REGOUTx = WRITEDATA combinationally in the same cycle.
  - Each port is evaluated independently.
  - No forwarding occurs while READY=0.
- REGFILE_BYPASS_EN undefined: reads always return stored contents. There is no combinational path from WRITEDATA or WRITEREG to REGOUTx.

## Structure
- Shared package reg_file_pkg holds:
  - the state typedef (INIT, RUN);
  - default DATA_WIDTH/ADDR_WIDTH constants for the processor (8 and 3).
- Sub-module reg_file_init_ctrl holds the INIT/RUN state machine, the sweep pointer and READY. It outputs a clear-enable and the clear address.
- The top level holds the storage array, the write mux (clear vs. normal write) and the read muxes.

## Test plan
- RESET=0 for 2 edges, then 1: READY=0 and REGOUT1/2=0 for 8 edges; READY=1 after the 8th edge; all registers read 0.
- RUN: write 95 to r2 with WRITEENABLE=1, then READREG1=2: REGOUT1=0 before the edge and 95 after it. With WRITEENABLE=0 and WRITEDATA=28, r2 stays 95.
- WRITEREG=3'b111 (-1), WRITEDATA=50: r7 reads 50; r0–r6 are unchanged.
- Write 6 then 15 to r4 on consecutive edges with READREG2=4:
  - with REGFILE_BYPASS_EN, REGOUT2 shows 6 and then 15 during each write cycle;
  - without it, REGOUT2 shows 6 and then 15 one edge later.
- Write 28 to r1 during INIT, wait for READY: r1 reads 0.
- Pull RESET=0 for 1 edge at sweep pointer 5, then release: READY stays 0 for 8 more edges, and a previously written r2=95 reads 0 after READY.
